// File: rtl/open_riscv_core_pkg.sv
// Shared definitions for the single-cycle RV32I core:
// bus type, reset levels, opcode/funct constants and ALU helpers.
package open_riscv_core_pkg;

  typedef logic [31:0] RegBus;

  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [2:0] F3Beq  = 3'd0;
  localparam logic [2:0] F3Bne  = 3'd1;
  localparam logic [2:0] F3Blt  = 3'd4;
  localparam logic [2:0] F3Bge  = 3'd5;
  localparam logic [2:0] F3Bltu = 3'd6;
  localparam logic [2:0] F3Bgeu = 3'd7;

  localparam logic [2:0] F3Lb  = 3'd0;
  localparam logic [2:0] F3Lh  = 3'd1;
  localparam logic [2:0] F3Lw  = 3'd2;
  localparam logic [2:0] F3Lbu = 3'd4;
  localparam logic [2:0] F3Lhu = 3'd5;

  localparam logic [2:0] F3Sb = 3'd0;
  localparam logic [2:0] F3Sh = 3'd1;
  localparam logic [2:0] F3Sw = 3'd2;

  localparam logic [2:0] F3Add  = 3'd0;
  localparam logic [2:0] F3Sll  = 3'd1;
  localparam logic [2:0] F3Slt  = 3'd2;
  localparam logic [2:0] F3Sltu = 3'd3;
  localparam logic [2:0] F3Xor  = 3'd4;
  localparam logic [2:0] F3Srl  = 3'd5;
  localparam logic [2:0] F3Or   = 3'd6;
  localparam logic [2:0] F3And  = 3'd7;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  // alt selects SUB over ADD and SRA over SRL
  function automatic RegBus alu(
    input logic [2:0] f3,
    input logic       alt,
    input RegBus      a,
    input RegBus      b
  );
    RegBus r;
    logic signed [31:0] sra;
    sra = $signed(a) >>> b[4:0];
    case (f3)
      F3Add:   r = alt ? a - b : a + b;
      F3Sll:   r = a << b[4:0];
      F3Slt:   r = {31'b0, $signed(a) < $signed(b)};
      F3Sltu:  r = {31'b0, a < b};
      F3Xor:   r = a ^ b;
      F3Srl:   r = alt ? RegBus'(sra) : a >> b[4:0];
      F3Or:    r = a | b;
      F3And:   r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic br_cond(
    input logic [2:0] f3,
    input RegBus      a,
    input RegBus      b
  );
    logic t;
    case (f3)
      F3Beq:   t = a == b;
      F3Bne:   t = a != b;
      F3Blt:   t = $signed(a) < $signed(b);
      F3Bge:   t = $signed(a) >= $signed(b);
      F3Bltu:  t = a < b;
      F3Bgeu:  t = a >= b;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/open_riscv_core_regs.sv
// 32 x 32-bit integer register file, two combinational reads,
// one synchronous write; x0 reads as zero and ignores writes.
import open_riscv_core_pkg::*;

module regs (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [4:0] waddr,
  input  RegBus      wdata,
  input  logic [4:0] raddr1,
  output RegBus      rdata1,
  input  logic [4:0] raddr2,
  output RegBus      rdata2
);

  RegBus regs [0:31];

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/open_riscv_core_sim_ram.sv
// Unified instruction/data RAM: combinational reads on both ports,
// byte-enabled synchronous write. Addresses wrap within the array.
import open_riscv_core_pkg::*;

module sim_ram #(
  parameter int RAM_DEPTH = 4096
) (
  input  logic       clk,
  input  RegBus      iaddr,
  output RegBus      idata,
  input  RegBus      daddr,
  output RegBus      drdata,
  input  logic [3:0] be,
  input  RegBus      wdata
);

  localparam int AW = $clog2(RAM_DEPTH);

  RegBus ram [0:RAM_DEPTH-1];

  logic [AW-1:0] iidx;
  logic [AW-1:0] didx;
  logic          unused_addr;

  assign iidx = iaddr[AW+1:2];
  assign didx = daddr[AW+1:2];

  assign unused_addr = ^{iaddr[31:AW+2], iaddr[1:0],
                         daddr[31:AW+2], daddr[1:0]};

  assign idata  = ram[iidx];
  assign drdata = ram[didx];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        ram[didx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/open_riscv_core.sv
// Single-cycle RV32I core: fetch, decode, execute, memory and
// writeback all complete in one clock; one instruction per cycle.
import open_riscv_core_pkg::*;

module open_riscv_core #(
  parameter int          RAM_DEPTH = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);

  RegBus      pc;
  RegBus      pc_next;
  RegBus      pc_plus4;
  RegBus      instr;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  RegBus      imm_i;
  RegBus      imm_s;
  RegBus      imm_b;
  RegBus      imm_u;
  RegBus      imm_j;

  RegBus      rs1_val;
  RegBus      rs2_val;
  RegBus      alu_b;
  RegBus      alu_out;
  logic       alu_alt;

  RegBus      daddr;
  RegBus      drdata;
  RegBus      load_val;
  RegBus      st_data;
  logic [3:0] st_be;
  logic [3:0] ram_be;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;

  logic       mem_we;
  logic       rd_we;
  RegBus      rd_val;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  assign pc_plus4 = pc + 32'd4;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  // immediate shifts carry the SRA flag in bit 30, ADDI does not
  assign alu_alt = instr[30] &
                   ((opcode == OpReg) | (funct3 == F3Srl));
  assign alu_b   = (opcode == OpReg) ? rs2_val : imm_i;
  assign alu_out = alu(funct3, alu_alt, rs1_val, alu_b);

  assign daddr = rs1_val +
                 ((opcode == OpStore) ? imm_s : imm_i);

  always_comb begin
    byte_sel = 8'(drdata >> {daddr[1:0], 3'b000});
    half_sel = daddr[1] ? drdata[31:16] : drdata[15:0];
    case (funct3)
      F3Lb:    load_val = {{24{byte_sel[7]}}, byte_sel};
      F3Lh:    load_val = {{16{half_sel[15]}}, half_sel};
      F3Lbu:   load_val = {24'b0, byte_sel};
      F3Lhu:   load_val = {16'b0, half_sel};
      default: load_val = drdata;
    endcase
  end

  always_comb begin
    st_be   = 4'b0000;
    st_data = rs2_val;
    case (funct3)
      F3Sb: begin
        st_be   = 4'b0001 << daddr[1:0];
        st_data = {4{rs2_val[7:0]}};
      end
      F3Sh: begin
        st_be   = daddr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{rs2_val[15:0]}};
      end
      F3Sw: st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  assign ram_be = (mem_we && rst == RstDisable) ? st_be : 4'b0000;

  always_comb begin
    pc_next = pc_plus4;
    rd_we   = 1'b0;
    rd_val  = alu_out;
    mem_we  = 1'b0;
    unique case (opcode)
      OpLui: begin
        rd_we  = 1'b1;
        rd_val = imm_u;
      end
      OpAuipc: begin
        rd_we  = 1'b1;
        rd_val = pc + imm_u;
      end
      OpJal: begin
        rd_we   = 1'b1;
        rd_val  = pc_plus4;
        pc_next = pc + imm_j;
      end
      OpJalr: begin
        rd_we   = 1'b1;
        rd_val  = pc_plus4;
        pc_next = (rs1_val + imm_i) & ~32'd1;
      end
      OpBranch: begin
        if (br_cond(funct3, rs1_val, rs2_val)) begin
          pc_next = pc + imm_b;
        end
      end
      OpLoad: begin
        rd_we  = 1'b1;
        rd_val = load_val;
      end
      OpStore: mem_we = 1'b1;
      OpImm:   rd_we  = 1'b1;
      OpReg:   rd_we  = 1'b1;
      default: ;
    endcase
  end

  regs u_regs (
    .clk    (clk),
    .rst    (rst),
    .we     (rd_we),
    .waddr  (rd),
    .wdata  (rd_val),
    .raddr1 (rs1),
    .rdata1 (rs1_val),
    .raddr2 (rs2),
    .rdata2 (rs2_val)
  );

  sim_ram #(
    .RAM_DEPTH (RAM_DEPTH)
  ) u_sim_ram (
    .clk    (clk),
    .iaddr  (pc),
    .idata  (instr),
    .daddr  (daddr),
    .drdata (drdata),
    .be     (ram_be),
    .wdata  (st_data)
  );

endmodule

// File: tb/tb_open_riscv_core.sv
// Directed program run on open_riscv_core: ALU, memory lanes,
// branches/jumps, reset behaviour and RAM retention over reset.
module tb_open_riscv_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic [31:0] prog [0:37];

  always #5 clk = ~clk;

  open_riscv_core u_dut (
    .clk (clk),
    .rst (rst)
  );

  function automatic logic [31:0] i_t(input int imm, input int rs1,
    input int f3, input int rd, input logic [6:0] op);
    logic [31:0] m;
    m = imm;
    return {m[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] r_t(input int f7, input int rs2,
    input int rs1, input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] s_t(input int imm, input int rs2,
    input int rs1, input int f3);
    logic [31:0] m;
    m = imm;
    return {m[11:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] b_t(input int imm, input int rs2,
    input int rs1, input int f3);
    logic [31:0] m;
    m = imm;
    return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3),
            m[4:1], m[11], 7'h63};
  endfunction

  function automatic logic [31:0] j_t(input int imm, input int rd);
    logic [31:0] m;
    m = imm;
    return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6f};
  endfunction

  function automatic logic [31:0] u_t(input int imm, input int rd,
    input logic [6:0] op);
    logic [31:0] m;
    m = imm;
    return {m[19:0], 5'(rd), op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
    input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rx(input int i);
    return u_dut.u_regs.regs[i];
  endfunction

  initial begin
    prog[0]  = i_t(-1, 0, 0, 1, 7'h13);
    prog[1]  = i_t(1, 0, 0, 2, 7'h13);
    prog[2]  = r_t(32, 2, 1, 0, 3);
    prog[3]  = r_t(0, 1, 2, 3, 4);
    prog[4]  = i_t(5, 0, 0, 0, 7'h13);
    prog[5]  = b_t(8, 2, 1, 1);
    prog[6]  = i_t(32'h77, 0, 0, 6, 7'h13);
    prog[7]  = i_t(32'h40, 0, 0, 5, 7'h13);
    prog[8]  = j_t(8, 1);
    prog[9]  = i_t(32'h55, 0, 0, 6, 7'h13);
    prog[10] = i_t(1, 5, 0, 0, 7'h67);
    for (int i = 11; i < 16; i++) prog[i] = i_t(32'h99, 0, 0, 7, 7'h13);
    prog[16] = u_t(32'h11223, 8, 7'h37);
    prog[17] = i_t(32'h344, 8, 0, 8, 7'h13);
    prog[18] = i_t(32'h100, 0, 0, 9, 7'h13);
    prog[19] = s_t(0, 8, 9, 2);
    prog[20] = i_t(-86, 0, 0, 10, 7'h13);
    prog[21] = s_t(1, 10, 9, 0);
    prog[22] = i_t(0, 9, 2, 11, 7'h03);
    prog[23] = i_t(1, 9, 0, 12, 7'h03);
    prog[24] = i_t(2, 9, 5, 13, 7'h03);
    prog[25] = i_t(0, 9, 1, 14, 7'h03);
    prog[26] = i_t(1, 9, 4, 15, 7'h03);
    prog[27] = i_t(-16, 0, 0, 16, 7'h13);
    prog[28] = i_t(32'h402, 16, 5, 17, 7'h13);
    prog[29] = i_t(28, 16, 5, 18, 7'h13);
    prog[30] = r_t(0, 2, 16, 2, 19);
    prog[31] = u_t(1, 20, 7'h17);
    prog[32] = s_t(6, 2, 9, 1);
    prog[33] = 32'h0000_0073;
    prog[34] = b_t(8, 2, 16, 5);
    prog[35] = b_t(8, 16, 2, 6);
    prog[36] = i_t(1, 0, 0, 21, 7'h13);
    prog[37] = j_t(0, 0);

    rst = 1'b1;
    step(1);
    for (int i = 0; i < 128; i++) begin
      u_dut.u_sim_ram.ram[i] <= (i < 38) ? prog[i] : 32'h0;
    end
    step(1);
    chk("reset_pc", u_dut.pc, 32'h0);
    chk("first_fetch", u_dut.instr, prog[0]);
    chk("reset_x1", rx(1), 32'h0);

    @(negedge clk);
    rst = 1'b0;
    step(4);
    chk("sub_x3", rx(3), 32'hFFFF_FFFE);
    chk("sltu_x4", rx(4), 32'h1);
    step(4);
    chk("jal_pc", u_dut.pc, 32'h28);
    chk("jal_link", rx(1), 32'h24);
    step(1);
    chk("jalr_pc", u_dut.pc, 32'h40);
    step(30);
    chk("x0_zero", rx(0), 32'h0);
    chk("bne_skip_x6", rx(6), 32'h0);
    chk("jalr_skip_x7", rx(7), 32'h0);
    chk("lui_addi_x8", rx(8), 32'h1122_3344);
    chk("lw_x11", rx(11), 32'h1122_AA44);
    chk("lb_x12", rx(12), 32'hFFFF_FFAA);
    chk("lhu_x13", rx(13), 32'h0000_1122);
    chk("lh_x14", rx(14), 32'hFFFF_AA44);
    chk("lbu_x15", rx(15), 32'h0000_00AA);
    chk("srai_x17", rx(17), 32'hFFFF_FFFC);
    chk("srli_x18", rx(18), 32'h0000_000F);
    chk("slt_x19", rx(19), 32'h1);
    chk("auipc_x20", rx(20), 32'h0000_107C);
    chk("bltu_skip_x21", rx(21), 32'h0);
    chk("mem_0x100", u_dut.u_sim_ram.ram[64], 32'h1122_AA44);
    chk("sh_0x104", u_dut.u_sim_ram.ram[65], 32'h0001_0000);
    chk("halt_pc", u_dut.pc, 32'h94);

    rst = 1'b1;
    step(2);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("rst_x%0d", i), rx(i), 32'h0);
    end
    chk("rst_pc", u_dut.pc, 32'h0);
    chk("rst_keep_mem", u_dut.u_sim_ram.ram[64], 32'h1122_AA44);

    rst = 1'b0;
    step(1);
    chk("restart_x1", rx(1), 32'hFFFF_FFFF);
    chk("restart_pc", u_dut.pc, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
